// File: rtl/sram_controller_pkg.sv
// Shared definitions for the ZBT SRAM controller: default widths, ZBT pipeline latency,
// control pin active levels and the request-tracking record.
package sram_controller_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 32;
    localparam int ZBT_LATENCY = 2;

    // Tracking depth covers address phase, data phase and the read capture edge
    localparam int PIPE_DEPTH  = ZBT_LATENCY + 1;

    localparam logic XWA_WRITE = 1'b0;
    localparam logic XE_SEL    = 1'b0;

    typedef struct packed {
        logic valid;
        logic we;
    } req_t;

endpackage

// File: rtl/sram_req_pipe.sv
// Shift register of {valid, we}: stage k holds the request issued k+1 edges ago.
module sram_req_pipe
    import sram_controller_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  req_t                   req_in,
    output req_t [DEPTH-1:0]       stage
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage <= {stage[DEPTH-2:0], req_in};
        end
    end

endmodule

// File: rtl/sram_controller.sv
// ZBT SRAM controller: registers control to pads, times store data to the ZBT data phase,
// owns the zd tristate and returns load data. Optional feature: SRAM_ADDR_CHECK_EN.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [31:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              addr_err,
    output logic [ADDR_W-1:0] za,
    output logic              xwa,
    output logic              xe1,
    inout  wire  [DATA_W-1:0] zd
);

    logic                  accept;
    req_t                  req_in;
    req_t [PIPE_DEPTH-1:0] stage;
    logic [DATA_W-1:0]     wd_pipe;
    logic [DATA_W-1:0]     zd_out;
    logic                  zd_oe;

`ifdef SRAM_ADDR_CHECK_EN
    logic addr_bad;
    logic addr_err_q;

    assign addr_bad = mem_req && (|mem_addr[31:ADDR_W]);
    assign accept   = mem_req && !addr_bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err_q <= 1'b0;
        end else if (addr_bad) begin
            addr_err_q <= 1'b1;
        end
    end

    assign addr_err = addr_err_q;
`else
    logic unused_addr_hi;

    assign unused_addr_hi = ^mem_addr[31:ADDR_W];
    assign accept         = mem_req;
    assign addr_err       = 1'b0;
`endif

    assign req_in = '{valid: accept, we: mem_we};

    // Address phase: za holds its last value while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            za  <= '0;
            xe1 <= ~XE_SEL;
            xwa <= ~XWA_WRITE;
        end else if (accept) begin
            za  <= mem_addr[ADDR_W-1:0];
            xe1 <= XE_SEL;
            xwa <= mem_we ? XWA_WRITE : ~XWA_WRITE;
        end else begin
            xe1 <= ~XE_SEL;
            xwa <= ~XWA_WRITE;
        end
    end

    sram_req_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_req_pipe (
        .clk    (clk),
        .rst    (rst),
        .req_in (req_in),
        .stage  (stage)
    );

    // Store data arrives one cycle after the request and is driven two edges later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_pipe <= '0;
            zd_out  <= '0;
            zd_oe   <= 1'b0;
        end else begin
            if (stage[0].valid && stage[0].we) begin
                wd_pipe <= mem_wdata;
            end
            zd_oe <= stage[1].valid && stage[1].we;
            if (stage[1].valid && stage[1].we) begin
                zd_out <= wd_pipe;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= stage[2].valid && !stage[2].we;
            if (stage[2].valid && !stage[2].we) begin
                rd_data <= zd;
            end
        end
    end

    assign zd = zd_oe ? zd_out : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized scoreboard bench for sram_controller against a behavioural 2-cycle ZBT model.
module tb_sram_controller;
    import sram_controller_pkg::*;

    localparam int AW = SRAM_ADDR_W;
    localparam int DW = SRAM_DATA_W;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          addr_err;
    logic [AW-1:0] za;
    logic          xwa;
    logic          xe1;
    wire  [DW-1:0] zd;

    int total = 0;
    int bad = 0;
    int edge_cnt = 0;

    sram_controller #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .rd_data(rd_data), .rd_valid(rd_valid), .addr_err(addr_err),
        .za(za), .xwa(xwa), .xe1(xe1), .zd(zd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // ZBT SRAM model: control sampled at one edge, data phase two edges later
    typedef struct packed {
        logic          v;
        logic          we;
        logic [AW-1:0] a;
    } zop_t;

    zop_t          p0, p1;
    logic          sram_oe;
    logic [DW-1:0] sram_dq;
    logic [DW-1:0] sram_mem [int];

    function automatic logic [DW-1:0] sram_rd(input int a);
        return sram_mem.exists(a) ? sram_mem[a] : '0;
    endfunction

    assign zd = sram_oe ? sram_dq : 'z;

    always @(posedge clk) begin
        if (p1.v && p1.we) sram_mem[int'(p1.a)] = zd;
        if (p0.v && !p0.we) begin
            sram_oe <= 1'b1;
            sram_dq <= sram_rd(int'(p0.a));
        end else begin
            sram_oe <= 1'b0;
        end
        p1 <= p0;
        p0 <= '{v: !xe1, we: !xwa, a: za};
    end

    // Reference: loads return the latest store to the same word in issue order
    typedef struct {
        logic [DW-1:0] d;
        int            e;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] next_wd;
    logic          exp_err = 1'b0;

    function automatic logic [DW-1:0] ref_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic in_range(input logic [31:0] addr);
`ifdef SRAM_ADDR_CHECK_EN
        return (addr >> AW) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [DW-1:0] wd);
        int a;
        mem_req   = req;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = next_wd;
        next_wd   = wd;
        if (req) begin
            a = int'(addr % (32'd1 << AW));
            if (!in_range(addr)) begin
                exp_err = 1'b1;
            end else if (we) begin
                ref_mem[a] = wd;
            end else begin
                sb.push_back('{d: ref_rd(a), e: edge_cnt + 4});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, '0);
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rd_valid: got rd_valid=1 expected 0 (edge %0d)", edge_cnt);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("rd_data", 64'(rd_data), 64'(x.d));
                chk("rd_valid_edge", 64'(edge_cnt), 64'(x.e));
            end
        end
        if (!rst && sram_oe) chk("bus_contention_zd_oe", 64'(dut.zd_oe), 64'd0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        mem_req = 1'b0;
        mem_we = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        next_wd = '0;
        p0 = '0;
        p1 = '0;
        sram_oe = 1'b0;
        sram_dq = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_za", 64'(za), 64'd0);
        chk("reset_xwa", 64'(xwa), 64'd1);
        chk("reset_xe1", 64'(xe1), 64'd1);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_data", 64'(rd_data), 64'd0);
        chk("reset_addr_err", 64'(addr_err), 64'd0);
        rst = 1'b0;
        idle(2);

        // Store then immediate load of the same word
        drive(1'b1, 1'b1, 32'h10, 32'h1234_5678);
        chk("store_xwa", 64'(xwa), 64'd0);
        chk("store_za", 64'(za), 64'h10);
        drive(1'b1, 1'b0, 32'h10, '0);
        chk("load_xwa", 64'(xwa), 64'd1);
        idle(6);

        // Alternating store/load with no gaps
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1'b1, 1'b1, 32'(i), $urandom);
            else            drive(1'b1, 1'b0, 32'(i - 1), '0);
        end
        idle(6);

        // Single load after idle: one-cycle chip enable
        drive(1'b1, 1'b0, 32'h0FFFF, '0);
        chk("single_xe1_t1", 64'(xe1), 64'd0);
        chk("single_za", 64'(za), 64'h0FFFF);
        idle(1);
        chk("single_xe1_t2", 64'(xe1), 64'd1);
        idle(6);

        // Reset one cycle after a load issue: load is discarded
        drive(1'b1, 1'b0, 32'h5, '0);
        rst = 1'b1;
        #1;
        chk("async_rst_xe1", 64'(xe1), 64'd1);
        chk("async_rst_za", 64'(za), 64'd0);
        chk("async_rst_rd_valid", 64'(rd_valid), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        // Upper address bits
        drive(1'b1, 1'b0, 32'h0010_0000, '0);
`ifdef SRAM_ADDR_CHECK_EN
        chk("oor_xe1", 64'(xe1), 64'd1);
        chk("oor_addr_err", 64'(addr_err), 64'd1);
`else
        chk("wrap_xe1", 64'(xe1), 64'd0);
        chk("wrap_za", 64'(za), 64'd0);
        chk("wrap_addr_err", 64'(addr_err), 64'd0);
`endif
        drive(1'b1, 1'b0, 32'h4, '0);
        chk("after_oor_xe1", 64'(xe1), 64'd0);
        chk("after_oor_za", 64'(za), 64'h4);
        chk("after_oor_addr_err", 64'(addr_err), 64'(exp_err));
        idle(6);

        // Randomized traffic, including occasional upper-bit addresses
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) a = a | 32'h0100_0000;
            drive($urandom_range(0, 3) != 0, 1'($urandom % 2), a, $urandom);
        end
        idle(1);
        for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
        chk("drain_queue", 64'(sb.size()), 64'd0);
        chk("final_addr_err", 64'(addr_err), 64'(exp_err));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
